// File: rtl/block_accum_pkg.sv
// Shared types and default sizing for the block accumulator.
package block_accum_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        ACCUM = 2'd2,
        DONE  = 2'd3
    } accum_state_t;

    localparam int DEF_LOGDEPTH = 6;
    localparam int DEF_WIDTH    = 32;

    // A block sum of 2^logdepth words of width bits needs logdepth extra bits.
    function automatic int calc_accw(input int width, input int logdepth);
        return width + logdepth;
    endfunction

endpackage

// File: rtl/block_accumulator.sv
// Requests one block read, sums the streamed words and hands the sum downstream.
// Optional BLOCK_ACCUM_MAX_EN adds max_out, the largest word of the block.
module block_accumulator
    import block_accum_pkg::*;
#(
    parameter int LOGDEPTH = DEF_LOGDEPTH,
    parameter int WIDTH    = DEF_WIDTH,
    parameter int ACCW     = calc_accw(WIDTH, LOGDEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                EN_accum,
    output logic                RDY_accum,
    input  logic                RDY_block,
    output logic                EN_blockRead,
    input  logic                VALID_memVal,
    input  logic [WIDTH-1:0]    memVal_data,
    output logic [LOGDEPTH:0]   word_cnt,
    output logic                VALID_sum,
    output logic [ACCW-1:0]     sum_out,
    input  logic                EN_sumTaken
`ifdef BLOCK_ACCUM_MAX_EN
    ,
    output logic [WIDTH-1:0]    max_out
`endif
);

    localparam int                DEPTH    = 1 << LOGDEPTH;
    localparam logic [LOGDEPTH:0] LAST_IDX = (LOGDEPTH+1)'(DEPTH - 1);
    localparam logic [LOGDEPTH:0] CNT_ONE  = (LOGDEPTH+1)'(1);

    function automatic logic [ACCW-1:0] widen(input logic [WIDTH-1:0] d);
        return {{(ACCW-WIDTH){1'b0}}, d};
    endfunction

    accum_state_t      state;
    accum_state_t      state_nxt;
    logic [ACCW-1:0]   acc;
    logic [ACCW-1:0]   acc_sum;
    logic              word_ok;
    logic              last_word;
    logic              start_read;
    logic              sum_taken;

    assign word_ok    = (state == ACCUM) && VALID_memVal;
    assign last_word  = word_ok && (word_cnt == LAST_IDX);
    assign start_read = (state == REQ) && RDY_block;
    assign sum_taken  = (state == DONE) && EN_sumTaken;
    assign acc_sum    = acc + widen(memVal_data);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (EN_accum)    state_nxt = REQ;
            REQ:     if (RDY_block)   state_nxt = ACCUM;
            ACCUM:   if (last_word)   state_nxt = DONE;
            DONE:    if (EN_sumTaken) state_nxt = IDLE;
            default:                  state_nxt = IDLE;
        endcase
    end

    // Every output is a register; RDY_accum looks one state ahead so it is high in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RDY_accum    <= 1'b0;
            EN_blockRead <= 1'b0;
            word_cnt     <= '0;
            VALID_sum    <= 1'b0;
            sum_out      <= '0;
            acc          <= '0;
        end else begin
            RDY_accum    <= (state_nxt == IDLE);
            EN_blockRead <= start_read;

            if (start_read) begin
                acc      <= '0;
                word_cnt <= '0;
            end else if (word_ok) begin
                acc      <= acc_sum;
                word_cnt <= word_cnt + CNT_ONE;
            end else if (sum_taken) begin
                word_cnt <= '0;
            end

            if (last_word) begin
                sum_out   <= acc_sum;
                VALID_sum <= 1'b1;
            end else if (sum_taken) begin
                VALID_sum <= 1'b0;
            end
        end
    end

`ifdef BLOCK_ACCUM_MAX_EN
    function automatic logic [WIDTH-1:0] max_of(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        return (a > b) ? a : b;
    endfunction

    logic [WIDTH-1:0] max_acc;

    // Running maximum follows acc; the published copy moves with sum_out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_acc <= '0;
            max_out <= '0;
        end else begin
            if (start_read) begin
                max_acc <= '0;
            end else if (word_ok) begin
                max_acc <= max_of(max_acc, memVal_data);
            end
            if (last_word) begin
                max_out <= max_of(max_acc, memVal_data);
            end
        end
    end
`endif

endmodule

// File: tb/tb_block_accumulator.sv
// Randomized bench for block_accumulator against a block-sum reference model.
// Define BLOCK_ACCUM_MAX_EN to also cover max_out.
module tb_block_accumulator;

    localparam int DEPTH = 64;

    logic        clk;
    logic        rst_n;
    logic        EN_accum;
    logic        RDY_accum;
    logic        RDY_block;
    logic        EN_blockRead;
    logic        VALID_memVal;
    logic [31:0] memVal_data;
    logic [6:0]  word_cnt;
    logic        VALID_sum;
    logic [37:0] sum_out;
    logic        EN_sumTaken;
`ifdef BLOCK_ACCUM_MAX_EN
    logic [31:0] max_out;
`endif

    block_accumulator dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .EN_accum     (EN_accum),
        .RDY_accum    (RDY_accum),
        .RDY_block    (RDY_block),
        .EN_blockRead (EN_blockRead),
        .VALID_memVal (VALID_memVal),
        .memVal_data  (memVal_data),
        .word_cnt     (word_cnt),
        .VALID_sum    (VALID_sum),
        .sum_out      (sum_out),
        .EN_sumTaken  (EN_sumTaken)
`ifdef BLOCK_ACCUM_MAX_EN
        ,
        .max_out      (max_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] words [DEPTH];

    // Observations recorded by drive_block for the test tasks to judge.
    int          o_lat;
    int          o_pulses;
    int          o_cnt_err;
    int          o_early_err;
    int          o_sum_lat;
    int          o_stable_err;
    int          o_idle_err;
    logic [37:0] o_sum;
    logic [6:0]  o_cnt;
    logic        o_valid_after;
    logic [6:0]  o_cnt_after;
    logic [37:0] o_sum_after;
    logic        o_rdy_after;
`ifdef BLOCK_ACCUM_MAX_EN
    logic [31:0] o_max;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [37:0] model_sum();
        longint s = 0;
        for (int i = 0; i < DEPTH; i++) s += longint'(words[i]);
        return s[37:0];
    endfunction

    function automatic logic [31:0] model_max();
        logic [31:0] m = 0;
        for (int i = 0; i < DEPTH; i++) if (words[i] > m) m = words[i];
        return m;
    endfunction

    // One transaction: request, stream words[], then hold and release the sum.
    // n_send < DEPTH stops right after the n_send-th word (used for aborts).
    task automatic drive_block(input int gap_mode, input int rdy_delay, input int take_delay,
                               input bit strays, input int n_send);
        int accepted;
        int k;
        bit v;
        o_lat = -1; o_pulses = 0; o_cnt_err = 0; o_early_err = 0; o_sum_lat = -1;
        o_stable_err = 0; o_idle_err = 0;
        for (int t = 0; t < 50 && RDY_accum !== 1'b1; t++) tick();
        if (strays) begin
            for (int i = 0; i < 4; i++) begin
                VALID_memVal = 1'b1;
                memVal_data  = $urandom;
                tick();
            end
            VALID_memVal = 1'b0;
        end
        EN_accum  = 1'b1;
        RDY_block = (rdy_delay == 0);
        for (int t = 1; t <= 200 && o_lat < 0; t++) begin
            tick();
            EN_accum = 1'b0;
            if (EN_blockRead === 1'b1) begin
                o_lat = t;
                o_pulses++;
            end
            if (t == rdy_delay) RDY_block = 1'b1;
            VALID_memVal = strays && (o_lat < 0) && ($urandom_range(1) == 1);
            memVal_data  = $urandom;
        end
        RDY_block = 1'b0;
        if (o_lat < 0) return;
        accepted = 0;
        k = 0;
        while (accepted < n_send && k < 1000) begin
            case (gap_mode)
                0:       v = 1'b1;
                1:       v = (k % 2 == 0);
                default: v = ($urandom_range(2) != 0);
            endcase
            VALID_memVal = v;
            memVal_data  = v ? words[accepted] : $urandom;
            EN_sumTaken  = $urandom_range(1) == 1;
            tick();
            k++;
            if (v) accepted++;
            if (EN_blockRead === 1'b1) o_pulses++;
            if (word_cnt !== 7'(accepted)) o_cnt_err++;
            if (accepted < DEPTH && VALID_sum !== 1'b0) o_early_err++;
        end
        VALID_memVal = 1'b0;
        EN_sumTaken  = 1'b0;
        if (n_send < DEPTH) return;
        for (int t = 1; t <= 20; t++) begin
            if (VALID_sum === 1'b1) begin
                o_sum_lat = t;
                break;
            end
            tick();
        end
        o_sum = sum_out;
        o_cnt = word_cnt;
`ifdef BLOCK_ACCUM_MAX_EN
        o_max = max_out;
`endif
        for (int i = 0; i < take_delay; i++) begin
            EN_accum = 1'b1;
            tick();
            if (VALID_sum !== 1'b1 || sum_out !== o_sum || word_cnt !== o_cnt) o_stable_err++;
            if (EN_blockRead === 1'b1) o_pulses++;
        end
        EN_accum    = 1'b0;
        EN_sumTaken = 1'b1;
        tick();
        EN_sumTaken   = 1'b0;
        o_valid_after = VALID_sum;
        o_cnt_after   = word_cnt;
        o_sum_after   = sum_out;
        o_rdy_after   = RDY_accum;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (RDY_accum !== 1'b1 || EN_blockRead !== 1'b0) o_idle_err++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; EN_accum = 1'b0; RDY_block = 1'b0; VALID_memVal = 1'b0;
        memVal_data = '0; EN_sumTaken = 1'b0;
        repeat (3) tick();
        n_tests++; if (RDY_accum !== 1'b0) begin n_fail++; $display("FAIL reset_rdy_accum got=%0b exp=0", RDY_accum); end
        n_tests++; if (EN_blockRead !== 1'b0) begin n_fail++; $display("FAIL reset_en_blockread got=%0b exp=0", EN_blockRead); end
        n_tests++; if (word_cnt !== 7'd0) begin n_fail++; $display("FAIL reset_word_cnt got=%0d exp=0", word_cnt); end
        n_tests++; if (VALID_sum !== 1'b0) begin n_fail++; $display("FAIL reset_valid_sum got=%0b exp=0", VALID_sum); end
        n_tests++; if (sum_out !== 38'd0) begin n_fail++; $display("FAIL reset_sum_out got=%0h exp=0", sum_out); end
`ifdef BLOCK_ACCUM_MAX_EN
        n_tests++; if (max_out !== 32'd0) begin n_fail++; $display("FAIL reset_max_out got=%0h exp=0", max_out); end
`endif
        #2 rst_n = 1'b1;
        #1;
        n_tests++; if (RDY_accum !== 1'b0) begin n_fail++; $display("FAIL rdy_before_edge got=%0b exp=0", RDY_accum); end
        tick();
        n_tests++; if (RDY_accum !== 1'b1) begin n_fail++; $display("FAIL rdy_after_release got=%0b exp=1", RDY_accum); end
    endtask

    task automatic check_common(input string tag, input int exp_lat, input logic [37:0] exp_sum);
        n_tests++; if (o_lat !== exp_lat) begin n_fail++; $display("FAIL %s blockread_latency got=%0d exp=%0d", tag, o_lat, exp_lat); end
        n_tests++; if (o_pulses !== 1) begin n_fail++; $display("FAIL %s blockread_pulses got=%0d exp=1", tag, o_pulses); end
        n_tests++; if (o_cnt_err !== 0) begin n_fail++; $display("FAIL %s word_cnt_track errors=%0d exp=0", tag, o_cnt_err); end
        n_tests++; if (o_early_err !== 0) begin n_fail++; $display("FAIL %s early_valid_sum errors=%0d exp=0", tag, o_early_err); end
        n_tests++; if (o_sum_lat !== 1) begin n_fail++; $display("FAIL %s sum_latency got=%0d exp=1", tag, o_sum_lat); end
        n_tests++; if (o_sum !== exp_sum) begin n_fail++; $display("FAIL %s sum_out got=%0h exp=%0h", tag, o_sum, exp_sum); end
        n_tests++; if (o_cnt !== 7'd64) begin n_fail++; $display("FAIL %s word_cnt_done got=%0d exp=64", tag, o_cnt); end
        n_tests++; if (o_valid_after !== 1'b0) begin n_fail++; $display("FAIL %s valid_after_take got=%0b exp=0", tag, o_valid_after); end
        n_tests++; if (o_cnt_after !== 7'd0) begin n_fail++; $display("FAIL %s word_cnt_after_take got=%0d exp=0", tag, o_cnt_after); end
        n_tests++; if (o_sum_after !== exp_sum) begin n_fail++; $display("FAIL %s sum_retained got=%0h exp=%0h", tag, o_sum_after, exp_sum); end
        n_tests++; if (o_rdy_after !== 1'b1) begin n_fail++; $display("FAIL %s rdy_after_take got=%0b exp=1", tag, o_rdy_after); end
        n_tests++; if (o_idle_err !== 0) begin n_fail++; $display("FAIL %s idle_after_take errors=%0d exp=0", tag, o_idle_err); end
    endtask

    task automatic test_ones();
        for (int i = 0; i < DEPTH; i++) words[i] = 32'd1;
        drive_block(0, 0, 0, 1'b0, DEPTH);
        check_common("ones", 2, 38'd64);
    endtask

    task automatic test_full_scale();
        for (int i = 0; i < DEPTH; i++) words[i] = 32'hFFFF_FFFF;
        drive_block(2, 0, 0, 1'b0, DEPTH);
        check_common("full_scale", 2, 38'h3F_FFFF_FFC0);
    endtask

    task automatic test_gaps_strays();
        for (int i = 0; i < DEPTH; i++) words[i] = 32'(i);
        drive_block(1, 0, 0, 1'b1, DEPTH);
        check_common("gaps_strays", 2, 38'd2016);
    endtask

    task automatic test_stall();
        for (int i = 0; i < DEPTH; i++) words[i] = $urandom;
        drive_block(2, 10, 5, 1'b1, DEPTH);
        check_common("stall", 11, model_sum());
        n_tests++; if (o_stable_err !== 0) begin n_fail++; $display("FAIL stall hold_stable errors=%0d exp=0", o_stable_err); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < DEPTH; i++) words[i] = $urandom;
        drive_block(0, 0, 0, 1'b0, 30);
        n_tests++; if (word_cnt !== 7'd30) begin n_fail++; $display("FAIL abort word_cnt_before got=%0d exp=30", word_cnt); end
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if (RDY_accum !== 1'b0 || EN_blockRead !== 1'b0 || VALID_sum !== 1'b0)
            begin n_fail++; $display("FAIL abort_ctrl got=%0b%0b%0b exp=000", RDY_accum, EN_blockRead, VALID_sum); end
        n_tests++; if (word_cnt !== 7'd0) begin n_fail++; $display("FAIL abort_word_cnt got=%0d exp=0", word_cnt); end
        n_tests++; if (sum_out !== 38'd0) begin n_fail++; $display("FAIL abort_sum_out got=%0h exp=0", sum_out); end
        #1 rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) words[i] = 32'd2;
        drive_block(0, 0, 0, 1'b0, DEPTH);
        check_common("after_abort", 2, 38'd128);
    endtask

    task automatic test_random_blocks();
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < DEPTH; i++) words[i] = $urandom;
            drive_block(2, $urandom_range(4), $urandom_range(3), 1'b1, DEPTH);
            n_tests++;
            if (o_sum !== model_sum()) begin
                n_fail++; $display("FAIL random_block%0d sum_out got=%0h exp=%0h", b, o_sum, model_sum());
            end
            n_tests++;
            if (o_cnt_err !== 0 || o_pulses !== 1 || o_stable_err !== 0) begin
                n_fail++; $display("FAIL random_block%0d protocol cnt_err=%0d pulses=%0d stable_err=%0d exp=0/1/0",
                                    b, o_cnt_err, o_pulses, o_stable_err);
            end
        end
    endtask

`ifdef BLOCK_ACCUM_MAX_EN
    task automatic test_max();
        for (int i = 0; i < DEPTH; i++) words[i] = 32'(i * 3);
        drive_block(2, 0, 2, 1'b1, DEPTH);
        check_common("max", 2, 38'd6048);
        n_tests++; if (o_max !== 32'd189) begin n_fail++; $display("FAIL max_out got=%0d exp=189", o_max); end
        for (int i = 0; i < DEPTH; i++) words[i] = $urandom;
        drive_block(0, 0, 0, 1'b0, DEPTH);
        n_tests++; if (o_max !== model_max()) begin n_fail++; $display("FAIL max_out_random got=%0h exp=%0h", o_max, model_max()); end
    endtask
`endif

    initial begin
        test_reset();
        test_ones();
        test_full_scale();
        test_gaps_strays();
        test_stall();
        test_reset_mid();
        test_random_blocks();
`ifdef BLOCK_ACCUM_MAX_EN
        test_max();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout tests_run=%0d", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
